// File: rtl/led_mode_sequencer.sv
// Four-LED mode sequencer: a shared prescaler makes the tick, and a mode FSM
// selects between independent blink, chase, all-together blink and off.
module led_mode_sequencer #(
    parameter int CLKS_PER_TICK = 25000,
    parameter int RATE_1        = 500,
    parameter int RATE_2        = 250,
    parameter int RATE_3        = 100,
    parameter int RATE_4        = 50,
    parameter int CHASE_TICKS   = 250
) (
    input  logic       i_Clk,
    input  logic       i_Rst_L,
    input  logic       i_Next,
    input  logic       i_Pause,
    output logic       o_LED_1,
    output logic       o_LED_2,
    output logic       o_LED_3,
    output logic       o_LED_4,
    output logic [1:0] o_Mode
);

    typedef enum logic [1:0] {
        M_BLINK = 2'd0,
        M_CHASE = 2'd1,
        M_ALL   = 2'd2,
        M_OFF   = 2'd3
    } mode_e;

    localparam int RATE_M12 = (RATE_1 > RATE_2) ? RATE_1 : RATE_2;
    localparam int RATE_M34 = (RATE_3 > RATE_4) ? RATE_3 : RATE_4;
    localparam int RATE_MAX = (RATE_M12 > RATE_M34) ? RATE_M12 : RATE_M34;

    localparam int PW = (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;
    localparam int RW = (RATE_MAX > 1) ? $clog2(RATE_MAX) : 1;
    localparam int CW = (CHASE_TICKS > 1) ? $clog2(CHASE_TICKS) : 1;

    localparam logic [PW-1:0] PRESC_LAST = PW'(CLKS_PER_TICK - 1);
    localparam logic [CW-1:0] CHASE_LAST = CW'(CHASE_TICKS - 1);
    localparam logic [3:0][RW-1:0] RATE_LAST = {RW'(RATE_4 - 1), RW'(RATE_3 - 1),
                                                RW'(RATE_2 - 1), RW'(RATE_1 - 1)};

    mode_e              mode_q, mode_d;
    logic [PW-1:0]      presc_q, presc_d;
    logic [3:0][RW-1:0] cnt_q, cnt_d;
    logic [CW-1:0]      chase_cnt_q, chase_cnt_d;
    logic [1:0]         chase_idx_q, chase_idx_d;
    logic [3:0]         led_q, led_d;
    logic               tick;

    assign tick = (presc_q == PRESC_LAST) && !i_Pause;

    // Mode FSM: state register
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            mode_q <= M_BLINK;
        end else begin
            mode_q <= mode_d;
        end
    end

    // Mode FSM: next state; a held i_Next advances once per cycle
    always_comb begin
        mode_d = mode_q;
        if (i_Next) begin
            mode_d = mode_e'(mode_q + 2'd1);
        end
    end

    // Mode FSM: outputs
    always_comb begin
        o_Mode = mode_q;
        {o_LED_4, o_LED_3, o_LED_2, o_LED_1} = led_q;
    end

    // Datapath next state; mode entry wins over a coincident tick
    always_comb begin
        presc_d     = presc_q;
        cnt_d       = cnt_q;
        chase_cnt_d = chase_cnt_q;
        chase_idx_d = chase_idx_q;
        led_d       = led_q;
        if (i_Next) begin
            presc_d     = '0;
            cnt_d       = '0;
            chase_cnt_d = '0;
            chase_idx_d = '0;
            led_d       = (mode_d == M_CHASE) ? 4'b0001 : 4'b0000;
        end else if (mode_q != M_OFF && !i_Pause) begin
            presc_d = (presc_q == PRESC_LAST) ? '0 : presc_q + PW'(1);
            if (tick) begin
                case (mode_q)
                    M_BLINK: begin
                        for (int k = 0; k < 4; k++) begin
                            if (cnt_q[k] == RATE_LAST[k]) begin
                                cnt_d[k] = '0;
                                led_d[k] = ~led_q[k];
                            end else begin
                                cnt_d[k] = cnt_q[k] + RW'(1);
                            end
                        end
                    end
                    M_CHASE: begin
                        if (chase_cnt_q == CHASE_LAST) begin
                            chase_cnt_d = '0;
                            chase_idx_d = chase_idx_q + 2'd1;
                            led_d       = 4'b0001 << chase_idx_d;
                        end else begin
                            chase_cnt_d = chase_cnt_q + CW'(1);
                        end
                    end
                    M_ALL: begin
                        if (cnt_q[0] == RATE_LAST[0]) begin
                            cnt_d[0] = '0;
                            led_d    = {4{~led_q[0]}};
                        end else begin
                            cnt_d[0] = cnt_q[0] + RW'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            presc_q     <= '0;
            cnt_q       <= '0;
            chase_cnt_q <= '0;
            chase_idx_q <= '0;
            led_q       <= '0;
        end else begin
            presc_q     <= presc_d;
            cnt_q       <= cnt_d;
            chase_cnt_q <= chase_cnt_d;
            chase_idx_q <= chase_idx_d;
            led_q       <= led_d;
        end
    end

endmodule

// File: doc/led_mode_sequencer.md
Name: led_mode_sequencer

Overview:
Controller for the four-LED blink datapath on the 25 MHz board.
- A single shared prescaler produces a 1 ms tick.
- A mode state machine uses the tick to sequence the LEDs through four display patterns: independent-rate blink, chase, all-together blink, off.
- A one-cycle i_Next pulse from the debounced switch-filter block advances the mode. It sits between that filter and the LED pins.

Parameters:
CLKS_PER_TICK, 25000, clock cycles per tick (1 ms at 25 MHz); must be >= 1
RATE_1, 500, LED_1 half-period in ticks (1 Hz); must be >= 1
RATE_2, 250, LED_2 half-period in ticks (2 Hz); must be >= 1
RATE_3, 100, LED_3 half-period in ticks (5 Hz); must be >= 1
RATE_4, 50, LED_4 half-period in ticks (10 Hz); must be >= 1
CHASE_TICKS, 250, ticks each LED stays lit in chase mode; must be >= 1

Ports:
i_Clk  input  1  system clock, rising edge
i_Rst_L  input  1  reset, asynchronous assert, active-low
i_Next  input  1  single-cycle pulse; advance to next mode
i_Pause  input  1  level; while high, freeze the prescaler and hold LED state
o_LED_1  output  1  LED 1 drive
o_LED_2  output  1  LED 2 drive
o_LED_3  output  1  LED 3 drive
o_LED_4  output  1  LED 4 drive
o_Mode  output  2  current mode: 0 BLINK, 1 CHASE, 2 ALL, 3 OFF

Behaviour:
- One clock (i_Clk); reset is asynchronous and active-low (i_Rst_L). All registers clear on reset assertion, not on a clock edge.
- Reset state: o_Mode=0 (BLINK), all o_LED_n=0, prescaler=0, all tick counters=0, chase index=0.
- Prescaler:
  - Counts 0..CLKS_PER_TICK-1, then wraps to 0.
  - Internal tick is high for the one cycle in which prescaler == CLKS_PER_TICK-1 and i_Pause=0.
- Counter widths are sized from the parameters; all comparisons use equality, so counters never overflow.
- Mode FSM:
  - i_Next=1 sampled on an edge sets the next mode on that edge: BLINK->CHASE->ALL->OFF->BLINK.
  - o_Mode is registered, so it changes 1 cycle after the pulse.
  - Mode entry on that same edge: prescaler, tick counters and chase counter clear to 0; all LEDs clear to 0, except on entry to CHASE, where o_LED_1=1 and the others are 0.
- BLINK: four independent counters.
  - On a tick, counter k increments.
  - If counter k == RATE_k-1 on that tick, o_LED_k toggles and counter k returns to 0.
  - First toggle of LED_k is visible RATE_k*CLKS_PER_TICK cycles after mode entry (or after reset release).
- CHASE: exactly one LED is lit, index 0..3.
  - On a tick with chase counter == CHASE_TICKS-1, the counter clears and the index advances 1->2->3->4->1.
- ALL: counter 1 (RATE_1) alone toggles all four LEDs together; the LEDs are always equal.
- OFF: LEDs held at 0; prescaler and counters held at 0.
- Pause: while i_Pause=1, prescaler, counters and LEDs hold their values. i_Next is still honoured; the new mode's entry values apply and are then held.
- Priority on simultaneous events: i_Next beats tick; a tick coinciding with i_Next is discarded.
- Reset asserted mid-operation aborts immediately to the reset state.
- An i_Next held high for multiple cycles advances the mode once per cycle; single-pulse input is the caller's responsibility.

Test Plan:
(Bench parameters: CLKS_PER_TICK=4, RATE_1..4=5,4,3,2, CHASE_TICKS=3.)
1. Release reset, BLINK -> LED_4 first toggles 8 cycles after release, LED_3 at 12, LED_2 at 16, LED_1 at 20; each then toggles with period 2*RATE_k*4 cycles.
2. Pulse i_Next once -> o_Mode=1 on the next cycle, LED pattern 0001. After 12 cycles the pattern is 0010; 12 cycles later 0100, then 1000, then 0001.
3. Pulse i_Next 3 times from BLINK, one pulse every 2 cycles -> modes 1,2,3, all LEDs 0 in OFF. Hold 100 cycles -> LEDs stay 0. One more pulse -> o_Mode=0 and the step-1 timing restarts.
4. In ALL mode, assert i_Pause for 30 cycles just before the first toggle (cycle 19) -> no toggle while paused; toggle occurs 1 cycle after i_Pause falls; all four LEDs stay equal throughout.
5. Pulse i_Next in the same cycle as a tick in BLINK with LED_4 due to toggle -> mode becomes CHASE, LEDs=0001, no LED_4 toggle.
6. Assert i_Rst_L=0 asynchronously between clock edges while in CHASE -> outputs go to 0 and o_Mode to 0 before the next edge; after release, step-1 timing holds.
